// File: rtl/axistream_fifo_mem.sv
// Simple dual-port word store for the packet FIFO: synchronous write, asynchronous read.
// Storage is deliberately unreset; validity is tracked entirely by the pointers in the parent.
module axistream_fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH:0]   wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH:0]   rdata_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axistream_packet_fifo.sv
// Store-and-forward AXI-Stream FIFO with first-word-fall-through read and a count of complete
// packets held; pkt_avail also fires when full with no complete packet so oversize packets drain.
module axistream_packet_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  src_tvalid,
   output logic                  src_tready,
   input  logic [DATA_WIDTH-1:0] src_tdata,
   input  logic                  src_tlast,
   output logic                  dest_tvalid,
   input  logic                  dest_tready,
   output logic [DATA_WIDTH-1:0] dest_tdata,
   output logic                  dest_tlast,
   output logic                  pkt_avail,
   output logic [ADDR_WIDTH:0]   pkt_count,
   output logic [ADDR_WIDTH:0]   level
);

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]       pkt_count_q, pkt_count_d;
   logic                empty, full;
   logic                wr_fire, rd_fire;
   logic [DATA_WIDTH:0] rd_word;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

   // Pointers are already cleared while rst_n is low, so the reset term is needed only on ready.
   assign src_tready  = !full && rst_n;
   assign dest_tvalid = !empty;
   assign dest_tdata  = rd_word[DATA_WIDTH-1:0];
   assign dest_tlast  = rd_word[DATA_WIDTH];

   assign wr_fire = src_tvalid && src_tready;
   assign rd_fire = dest_tvalid && dest_tready;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      pkt_count_d = pkt_count_q;
      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({wr_fire && src_tlast, rd_fire && dest_tlast})
         2'b10:   pkt_count_d = pkt_count_q + PW'(1);
         2'b01:   pkt_count_d = pkt_count_q - PW'(1);
         default: pkt_count_d = pkt_count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pkt_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign level     = wr_ptr_q - rd_ptr_q;
   assign pkt_count = pkt_count_q;
   assign pkt_avail = (pkt_count_q != '0) || full;

   axistream_fifo_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_fire),
      .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata_i ({src_tlast, src_tdata}),
      .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata_o (rd_word)
   );

endmodule

// File: tb/tb_axistream_packet_fifo.sv
// Bench for axistream_packet_fifo: directed scenarios plus a random run against a queue model.
module tb_axistream_packet_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          src_tvalid = 1'b0;
   logic          src_tready;
   logic [DW-1:0] src_tdata = '0;
   logic          src_tlast = 1'b0;
   logic          dest_tvalid;
   logic          dest_tready = 1'b0;
   logic [DW-1:0] dest_tdata;
   logic          dest_tlast;
   logic          pkt_avail;
   logic [AW:0]   pkt_count;
   logic [AW:0]   level;

   int n_cmp = 0;
   int n_err = 0;

   // Model: the FIFO contents as a queue of {last,data}; everything else is derived from it.
   logic [DW:0] q[$];

   axistream_packet_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_tvalid (src_tvalid),
      .src_tready (src_tready),
      .src_tdata  (src_tdata),
      .src_tlast  (src_tlast),
      .dest_tvalid(dest_tvalid),
      .dest_tready(dest_tready),
      .dest_tdata (dest_tdata),
      .dest_tlast (dest_tlast),
      .pkt_avail  (pkt_avail),
      .pkt_count  (pkt_count),
      .level      (level)
   );

   always #5 clk = ~clk;

   function automatic int m_pkts();
      int c = 0;
      foreach (q[i]) if (q[i][DW]) c++;
      return c;
   endfunction

   function automatic logic m_avail();
      return (m_pkts() != 0) || (q.size() == DEPTH);
   endfunction

   // Advance one clock with the currently driven inputs and update the model.
   task automatic tick();
      bit fw, fr;
      fw = src_tvalid && rst_n && (q.size() < DEPTH);
      fr = dest_tready && rst_n && (q.size() > 0);
      @(posedge clk);
      if (fr) void'(q.pop_front());
      if (fw) q.push_back({src_tlast, src_tdata});
      @(negedge clk);
   endtask

   task automatic put(input logic [DW-1:0] d, input logic l);
      src_tvalid = 1'b1; src_tdata = d; src_tlast = l;
      tick();
      src_tvalid = 1'b0; src_tlast = 1'b0;
   endtask

   task automatic drain();
      dest_tready = 1'b1;
      for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) tick();
      dest_tready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; src_tvalid = 1'b1; src_tdata = 8'hEE; src_tlast = 1'b1; dest_tready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (src_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b exp 0", src_tready); end
      n_cmp++; if (dest_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b exp 0", dest_tvalid); end
      n_cmp++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL rst_avail: got %b exp 0", pkt_avail); end
      n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d exp 0", level); end
      n_cmp++; if (pkt_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", pkt_count); end
      src_tvalid = 1'b0; src_tlast = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      put(8'h01, 1'b1);
      put(8'h02, 1'b0);
      n_cmp++; if (level !== 5'd2) begin n_err++; $display("FAIL pre_async_level: got %0d exp 2", level); end
      // Assert reset between edges: outputs must clear without any clock.
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL async_level: got %0d exp 0", level); end
      n_cmp++; if (dest_tvalid !== 1'b0) begin n_err++; $display("FAIL async_tvalid: got %b exp 0", dest_tvalid); end
      n_cmp++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL async_avail: got %b exp 0", pkt_avail); end
      n_cmp++; if (src_tready !== 1'b0) begin n_err++; $display("FAIL async_tready: got %b exp 0", src_tready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_packet();
      logic [DW-1:0] exp_d [3];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
      dest_tready = 1'b0;
      put(8'h11, 1'b0);
      put(8'h22, 1'b0);
      n_cmp++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL sp_avail_early: got %b exp 0", pkt_avail); end
      put(8'h33, 1'b1);
      n_cmp++; if (level !== 5'd3) begin n_err++; $display("FAIL sp_level: got %0d exp 3", level); end
      n_cmp++; if (pkt_count !== 5'd1) begin n_err++; $display("FAIL sp_count: got %0d exp 1", pkt_count); end
      n_cmp++; if (pkt_avail !== 1'b1) begin n_err++; $display("FAIL sp_avail: got %b exp 1", pkt_avail); end
      dest_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (dest_tvalid !== 1'b1 || dest_tdata !== exp_d[i] || dest_tlast !== (i == 2))
            begin n_err++; $display("FAIL sp_word%0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, dest_tvalid, dest_tdata, dest_tlast, exp_d[i], (i == 2)); end
         tick();
      end
      dest_tready = 1'b0;
      n_cmp++; if (pkt_count !== 5'd0 || pkt_avail !== 1'b0 || dest_tvalid !== 1'b0)
         begin n_err++; $display("FAIL sp_after: got cnt=%0d av=%b v=%b exp 0 0 0", pkt_count, pkt_avail, dest_tvalid); end
   endtask

   task automatic test_partial();
      put(8'hA0, 1'b0);
      put(8'hA1, 1'b0);
      n_cmp++; if (pkt_avail !== 1'b0) begin n_err++; $display("FAIL part_avail: got %b exp 0", pkt_avail); end
      n_cmp++; if (dest_tvalid !== 1'b1 || dest_tdata !== 8'hA0) begin n_err++; $display("FAIL part_head: got v=%b d=%h exp v=1 d=a0", dest_tvalid, dest_tdata); end
      n_cmp++; if (level !== 5'd2) begin n_err++; $display("FAIL part_level: got %0d exp 2", level); end
      drain();
   endtask

   task automatic test_full_oversize();
      for (int i = 0; i < DEPTH; i++) put(8'(8'hC0 + i), 1'b0);
      n_cmp++; if (src_tready !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b exp 0", src_tready); end
      n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d exp 16", level); end
      n_cmp++; if (pkt_count !== 5'd0 || pkt_avail !== 1'b1) begin n_err++; $display("FAIL full_avail: got cnt=%0d av=%b exp 0 1", pkt_count, pkt_avail); end
      // Offer a word together with a read: only the read may happen.
      src_tvalid = 1'b1; src_tdata = 8'h99; src_tlast = 1'b1; dest_tready = 1'b1;
      tick();
      src_tvalid = 1'b0; src_tlast = 1'b0; dest_tready = 1'b0;
      n_cmp++; if (src_tready !== 1'b1 || level !== 5'd15) begin n_err++; $display("FAIL full_read1: got rdy=%b lvl=%0d exp 1 15", src_tready, level); end
      n_cmp++; if (dest_tdata !== 8'hC1 || pkt_count !== 5'd0) begin n_err++; $display("FAIL full_head: got d=%h cnt=%0d exp c1 0", dest_tdata, pkt_count); end
      drain();
   endtask

   task automatic test_back_to_back();
      int n_rd = 0;
      int bad = 0;
      logic [DW-1:0] exp_next = 8'h40;
      dest_tready = 1'b1; src_tvalid = 1'b1; src_tlast = 1'b1;
      for (int i = 0; i < 50; i++) begin
         src_tdata = 8'(8'h40 + i);
         if (dest_tvalid) begin
            if (dest_tdata !== exp_next || dest_tlast !== 1'b1) bad++;
            exp_next++;
            n_rd++;
         end
         tick();
         if (level !== 5'd1 || pkt_count !== 5'd1) bad++;
      end
      src_tvalid = 1'b0; src_tlast = 1'b0;
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_steady: got %0d bad cycles exp 0", bad); end
      n_cmp++; if (n_rd !== 49) begin n_err++; $display("FAIL b2b_throughput: got %0d reads exp 49", n_rd); end
      drain();
   endtask

   task automatic test_reset_mid_packet();
      for (int i = 0; i < 5; i++) put(8'(8'h70 + i), 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (level !== 5'd0 || pkt_count !== 5'd0) begin n_err++; $display("FAIL rmp_clear: got lvl=%0d cnt=%0d exp 0 0", level, pkt_count); end
      put(8'h55, 1'b1);
      n_cmp++; if (dest_tvalid !== 1'b1 || dest_tdata !== 8'h55 || dest_tlast !== 1'b1 || pkt_avail !== 1'b1)
         begin n_err++; $display("FAIL rmp_pkt: got v=%b d=%h l=%b av=%b exp 1 55 1 1", dest_tvalid, dest_tdata, dest_tlast, pkt_avail); end
      dest_tready = 1'b1;
      tick();
      dest_tready = 1'b0;
      n_cmp++; if (dest_tvalid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL rmp_alone: got v=%b lvl=%0d exp 0 0", dest_tvalid, level); end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 600; i++) begin
         src_tvalid  = ($urandom_range(0, 3) != 0);
         src_tdata   = 8'($urandom);
         src_tlast   = ($urandom_range(0, 5) == 0);
         dest_tready = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         if (q.size() > 0 && (dest_tvalid !== 1'b1 || {dest_tlast, dest_tdata} !== q[0])) begin
            bad++;
            if (bad < 5) $display("FAIL rnd_head cyc %0d: got %b/%h exp %h", i, dest_tvalid, {dest_tlast, dest_tdata}, q[0]);
         end
         tick();
         if (level !== 5'(q.size()) || pkt_count !== 5'(m_pkts()) || pkt_avail !== m_avail() ||
             src_tready !== (q.size() < DEPTH) || dest_tvalid !== (q.size() > 0)) begin
            bad++;
            if (bad < 5) $display("FAIL rnd_state cyc %0d: got lvl=%0d cnt=%0d av=%b exp lvl=%0d cnt=%0d av=%b",
                                  i, level, pkt_count, pkt_avail, q.size(), m_pkts(), m_avail());
         end
      end
      src_tvalid = 1'b0; src_tlast = 1'b0;
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rnd_total: got %0d bad cycles exp 0", bad); end
      drain();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_packet();
      test_partial();
      test_full_oversize();
      test_back_to_back();
      test_reset_mid_packet();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
